// File: rtl/spi_master_interface.sv
// SPI master: serialises one command word MSB first over MOSI/SS_n.
// On read-data opcodes it also shifts in a reply from MISO. clk doubles as SCK.
module spi_master_interface #(
    parameter int CMD_WIDTH  = 10,
    parameter int DATA_WIDTH = 8,
    parameter int TURNAROUND = 2,
    parameter int IDLE_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CMD_WIDTH-1:0]  cmd_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  SS_n
);

    localparam int MAX_A = (CMD_WIDTH > DATA_WIDTH) ? CMD_WIDTH : DATA_WIDTH;
    localparam int MAX_B = (TURNAROUND > IDLE_GAP) ? TURNAROUND : IDLE_GAP;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SEND,
        S_TURN,
        S_RECV,
        S_GAP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CMD_WIDTH-1:0]  r_cmd;
    logic                  r_is_read;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_mosi;
    logic                  r_ss_n;

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CMD_WIDTH-1:0]  w_cmd_next;
    logic                  w_is_read_next;
    logic [DATA_WIDTH-1:0] w_shreg_next;
    logic [DATA_WIDTH-1:0] w_rx_data_next;
    logic                  w_rx_valid_next;
    logic                  w_done_next;
    logic                  w_busy_next;
    logic                  w_mosi_next;
    logic                  w_ss_n_next;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = {r_shreg[DATA_WIDTH-2:0], MISO};

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cmd_next      = r_cmd;
        w_is_read_next  = r_is_read;
        w_shreg_next    = r_shreg;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_busy_next     = r_busy;
        w_mosi_next     = r_mosi;
        w_ss_n_next     = r_ss_n;

        case (r_state)
            S_IDLE: begin
                w_ss_n_next = 1'b1;
                w_mosi_next = 1'b0;
                w_busy_next = 1'b0;
                if (start) begin
                    w_cmd_next     = cmd_in;
                    w_is_read_next = (cmd_in[CMD_WIDTH-1:CMD_WIDTH-2] == 2'b11);
                    w_ss_n_next    = 1'b0;
                    w_mosi_next    = cmd_in[CMD_WIDTH-1];
                    w_busy_next    = 1'b1;
                    w_state_next   = S_SELECT;
                end
            end
            S_SELECT: begin
                w_mosi_next  = r_cmd[CMD_WIDTH-1];
                w_cnt_next   = CNT_W'(CMD_WIDTH - 1);
                w_state_next = S_SEND;
            end
            // r_cmd shifts left so its MSB is always the bit on the wire.
            S_SEND: begin
                if (r_cnt == '0) begin
                    w_mosi_next = 1'b0;
                    w_cnt_next  = '0;
                    if (r_is_read) begin
                        w_state_next = S_TURN;
                    end else begin
                        w_ss_n_next  = 1'b1;
                        w_state_next = S_GAP;
                    end
                end else begin
                    w_mosi_next = r_cmd[CMD_WIDTH-2];
                    w_cmd_next  = {r_cmd[CMD_WIDTH-2:0], 1'b0};
                    w_cnt_next  = r_cnt - CNT_W'(1);
                end
            end
            S_TURN: begin
                w_mosi_next = 1'b0;
                if (r_cnt == CNT_W'(TURNAROUND - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_RECV;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RECV: begin
                w_mosi_next  = 1'b0;
                w_shreg_next = w_shifted;
                if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    w_rx_data_next  = w_shifted;
                    w_rx_valid_next = 1'b1;
                    w_ss_n_next     = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                w_ss_n_next = 1'b1;
                w_mosi_next = 1'b0;
                if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
                    w_busy_next  = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // done is registered, so it is raised on entry to the last GAP cycle.
        w_done_next = (w_state_next == S_GAP) && (w_cnt_next == CNT_W'(IDLE_GAP - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_is_read  <= 1'b0;
            r_shreg    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cmd      <= w_cmd_next;
            r_is_read  <= w_is_read_next;
            r_shreg    <= w_shreg_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_done     <= w_done_next;
            r_busy     <= w_busy_next;
            r_mosi     <= w_mosi_next;
            r_ss_n     <= w_ss_n_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign MOSI     = r_mosi;
    assign SS_n     = r_ss_n;

endmodule

// File: tb/tb_spi_master_interface.sv
// Directed bench for spi_master_interface with a behavioural SPI slave + RAM
// on the far side of MOSI/MISO/SS_n.
module tb_spi_master_interface;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] cmd_in = '0;
    logic       busy, done, rx_valid, MOSI, SS_n;
    logic       MISO = 1'b1;
    logic [7:0] rx_data;

    spi_master_interface dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd_in  (cmd_in),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .SS_n    (SS_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor, sampled on the falling edge.
    int          cyc = 0;
    int          low_run = 0, last_low = 0;
    int          busy_run = 0, last_busy = 0;
    int          done_cnt = 0, rxv_cnt = 0;
    int          fall_cyc = 0, rise_cyc = 0;
    logic [31:0] mosi_seq = '0, last_seq = '0;
    logic        prev_ssn = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!SS_n && prev_ssn) fall_cyc = cyc;
        if (SS_n && !prev_ssn) rise_cyc = cyc;
        prev_ssn = SS_n;
        if (!SS_n) begin
            low_run++;
            mosi_seq = {mosi_seq[30:0], MOSI};
        end else if (low_run != 0) begin
            last_low = low_run;
            last_seq = mosi_seq;
            low_run  = 0;
            mosi_seq = '0;
        end
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
        if (done) done_cnt++;
        if (rx_valid) rxv_cnt++;
    end

    // Slave model: cycle 1 is the opcode-check cycle, bits land in cycles 2..11,
    // reply bit 7 is presented before the master's first RECV sample (cycle 14).
    logic [7:0] ram [256];
    logic [7:0] wr_addr = '0, rd_addr = '0, reply = '0;
    logic [9:0] s_sh = '0;
    int         s_cnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0] = 8'h8A;
    end

    always @(negedge clk) begin
        if (SS_n) begin
            s_cnt = 0;
            MISO  = 1'b1;
        end else begin
            s_cnt++;
            if (s_cnt >= 2 && s_cnt <= 11) s_sh = {s_sh[8:0], MOSI};
            if (s_cnt == 11) begin
                case (s_sh[9:8])
                    2'b00: wr_addr = s_sh[7:0];
                    2'b01: ram[wr_addr] = s_sh[7:0];
                    2'b10: rd_addr = s_sh[7:0];
                    default: reply = ram[rd_addr];
                endcase
            end
            if (s_cnt >= 14 && s_cnt <= 21) MISO = reply[21 - s_cnt];
            else MISO = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 60) begin
            tick();
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_txn(input logic [9:0] c);
        int d0;
        d0 = done_cnt;
        cmd_in = c;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(d0);
        tick();
        tick();
        $display("txn cmd=%h ss_low=%0d busy=%0d mosi=%h rx_data=%h", c, last_low, last_busy, last_seq, rx_data);
    endtask

    int d0, r0, r1, n;

    initial begin
        #1 rst_n = 1'b0;
        start  = 1'b1;
        cmd_in = 10'h3FF;
        repeat (3) tick();
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_done_cnt", done_cnt, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        // Write address 0x01
        d0 = done_cnt; r0 = rxv_cnt;
        do_txn(10'h001);
        check("wa_ss_low", last_low, 11);
        check("wa_mosi_seq", last_seq, 32'h0000_0001);
        check("wa_done", done_cnt - d0, 1);
        check("wa_rx_valid", rxv_cnt - r0, 0);
        check("wa_busy_len", last_busy, 13);

        // Read data: slave rd_addr is 0, ram[0] = 8A
        d0 = done_cnt; r0 = rxv_cnt;
        do_txn(10'h300);
        check("rd_ss_low", last_low, 21);
        check("rd_mosi_seq", last_seq, 32'h001C_0000);
        check("rd_rx_data", {24'd0, rx_data}, 32'h8A);
        check("rd_rx_valid", rxv_cnt - r0, 1);
        check("rd_done", done_cnt - d0, 1);
        check("rd_busy_len", last_busy, 23);

        // start while busy is ignored; cmd_in changes after acceptance are ignored
        d0 = done_cnt;
        cmd_in = 10'h0F0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (5) tick();
        cmd_in = 10'h201;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cmd_in = 10'h3FF;
        wait_done(d0);
        repeat (4) tick();
        $display("txn cmd=0f0 (with ignored 201) ss_low=%0d mosi=%h busy=%0d", last_low, last_seq, busy);
        check("ign_mosi_seq", last_seq, 32'h0000_00F0);
        check("ign_ss_low", last_low, 11);
        check("ign_done", done_cnt - d0, 1);
        check("ign_busy", {31'd0, busy}, 32'd0);

        // Held start: second SS_n fall IDLE_GAP+1 cycles after first rise
        d0 = done_cnt;
        cmd_in = 10'h0F1;
        start  = 1'b1;
        tick();
        wait_done(d0);
        r1 = rise_cyc;
        n = 0;
        while (fall_cyc <= r1 && n < 20) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("b2b_gap", fall_cyc - r1, 3);
        wait_done(d0 + 1);
        repeat (3) tick();
        $display("txn cmd=0f1 x2 held start gap=%0d done=%0d", fall_cyc - r1, done_cnt - d0);
        check("b2b_done", done_cnt - d0, 2);

        // Reset in the middle of RECV
        d0 = done_cnt; r0 = rxv_cnt;
        cmd_in = 10'h300;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n = 0;
        while (low_run < 18 && n < 40) begin
            tick();
            n++;
        end
        check("abort_reached_recv", low_run, 18);
        rst_n = 1'b0;
        #1;
        check("abort_ss_n", {31'd0, SS_n}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        $display("txn cmd=300 aborted in RECV rx_data=%h ss_n=%b", rx_data, SS_n);
        check("abort_done", done_cnt - d0, 0);
        check("abort_rx_valid", rxv_cnt - r0, 0);
        check("abort_rx_data", {24'd0, rx_data}, 32'd0);
        check("abort_idle_ss_n", {31'd0, SS_n}, 32'd1);

        // End-to-end through the slave + RAM model
        d0 = done_cnt; r0 = rxv_cnt;
        do_txn(10'h001);
        do_txn(10'h18A);
        do_txn(10'h201);
        do_txn(10'h300);
        check("e2e_rx_data", {24'd0, rx_data}, 32'h8A);
        check("e2e_done", done_cnt - d0, 4);
        check("e2e_rx_valid", rxv_cnt - r0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
